pic_inta_initiator: RTL and testbench
=====================================

# pic_inta_initiator

CPU-side initiator for the interrupt-acknowledge protocol answered by the interrupt controller block. Watches the controller's INT line, runs the two-pulse INTA_n sequence, captures the vector byte driven on the second pulse, and hands it to the core over a valid/ready handshake. When compiled in, it also writes the non-specific EOI command (OCW2 = 0x20, A0 = 0) back to the controller on request.

## Interface
- PULSE_CYC, 2: clocks each INTA_n / WR_n low pulse lasts; legal range is 1 or more.
- GAP_CYC, 2: clocks of high time between the two INTA_n pulses, and after each WR_n pulse; legal range is 1 or more.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- int_in  input  1  INT from the controller; asynchronous, synchronized internally.
- int_enable  input  1  core interrupt-enable flag; gates sequence start only.
- data_in  input  8  controller data bus; sampled on the second pulse.
- inta_n  output  1  acknowledge strobe to the controller; registered.
- vector  output  8  captured vector byte.
- vector_valid  output  1  vector available.
- vector_ready  input  1  core accepts the vector.
- eoi_req  input  1  core requests EOI; level, held until eoi_ack.
- eoi_ack  output  1  one-cycle pulse when the EOI write completes.
- wr_n  output  1  write strobe to the controller; registered.
- a0  output  1  controller address bit; always 0 during EOI.
- data_out  output  8  write data.
- data_oe  output  1  data_out drive enable.
- busy  output  1  high whenever state is not IDLE.

## Operation
- int_in passes through a 2-flop synchronizer to give int_s.
- FSM states: IDLE, P1, G1, P2, VEC, EW, EG.
- IDLE, EOI: if eoi_req is high (EOI compiled in), go to EW. EOI has priority over a pending interrupt.
- IDLE, interrupt: else if int_s is 1 and int_enable is 1, go to P1.
- P1: inta_n = 0 for PULSE_CYC clocks, then go to G1. No data is sampled in P1.
- G1: inta_n = 1 for GAP_CYC clocks, then go to P2. If int_s drops during P1 or G1, the sequence still completes; the controller is responsible for spurious vectors.
- P2: inta_n = 0 for PULSE_CYC clocks. On the last P2 clock, data_in is latched into vector. Then go to VEC.
- VEC: vector_valid = 1, held until vector_valid and vector_ready are both 1 on a clock edge. vector_valid then clears and the FSM returns to IDLE. vector holds its value until the next capture.
- EW: wr_n = 0, a0 = 0, data_out = 0x20, data_oe = 1, for PULSE_CYC clocks. Then go to EG.
- EG: wr_n = 1 and data_oe = 1 for GAP_CYC clocks; data_oe is held through EG as hold time. On exit, eoi_ack pulses for 1 cycle, data_oe goes to 0, and the FSM returns to IDLE.
- eoi_req asserted outside IDLE is serviced on the next IDLE clock.
- Counter width is $clog2(max(PULSE_CYC, GAP_CYC) + 1). The counter loads N-1 on state entry, decrements, and the state exits at 0.
- Reset, applied any time including mid-pulse, forces every output to its reset value within the reset assertion, with no glitch to 0:
  - inta_n = 1, wr_n = 1.
  - a0 = 0, data_out = 0x00, data_oe = 0.
  - vector = 0x00, vector_valid = 0.
  - eoi_ack = 0, busy = 0.
  - state = IDLE, synchronizer flops cleared.

## Timing
- int_in rising to inta_n falling takes 3 clocks: 2 for synchronization plus 1 for the IDLE→P1 register.
- First INTA_n falling edge to vector_valid rising takes 2·PULSE_CYC + GAP_CYC clocks.
- Vector handoff:
  - vector_ready already high when VEC is entered: accepted in the first VEC cycle.
  - Minimum IDLE-to-IDLE interrupt cost is 2·PULSE_CYC + GAP_CYC + 2 clocks.
- EOI write takes PULSE_CYC + GAP_CYC clocks from EW entry to eoi_ack.
- All strobes come straight from flops; none are combinational.

## Configuration
- PIC_INTA_EOI_WRITER_EN defined: EW and EG states and the eoi_req path are present.
- Macro undefined:
  - eoi_req is ignored and eoi_ack is tied 0.
  - wr_n is tied 1; a0, data_out and data_oe are tied 0.
  - EW and EG are removed from the state encoding.

## Structure
- A shared package holds:
  - the state enum;
  - the OCW2 non-specific EOI constant, 8'h20;
  - the default PULSE_CYC and GAP_CYC values.
- One sub-module, pic_sync2: a 2-flop synchronizer with async active-low reset.

## Test plan
- Default parameters, data_in = 0x47, int_in pulsed high with int_enable = 1, vector_ready tied 1:
  - exactly two inta_n pulses, each 2 clocks low, with a 2-clock gap;
  - vector = 0x47, vector_valid high for 1 cycle;
  - busy returns low.
- int_enable = 0 with int_in high: no inta_n activity for 20 clocks. Raise int_enable → sequence starts 1 clock later.
- vector_ready held low 5 clocks in VEC: vector_valid stays high with vector stable; handoff completes on the clock vector_ready rises.
- eoi_req raised in IDLE together with int_in:
  - wr_n low 2 clocks with data_out = 0x20, a0 = 0;
  - eoi_ack pulses once;
  - the INTA sequence follows.
- rst_n asserted during P2: inta_n = 1, vector_valid = 0, vector = 0x00 immediately. After release with int_in still high, a full fresh two-pulse sequence runs.
- Build without PIC_INTA_EOI_WRITER_EN and hold eoi_req high for 50 clocks: wr_n stays 1 and eoi_ack stays 0.

Source files
------------

// File: rtl/pic_inta_initiator_pkg.sv
// Shared types and constants for the interrupt-acknowledge initiator.
// PIC_INTA_EOI_WRITER_EN adds the EOI write states to the state encoding.
package pic_inta_initiator_pkg;

    localparam int PULSE_CYC_DEF = 2;
    localparam int GAP_CYC_DEF   = 2;

    // OCW2 non-specific EOI command byte.
    localparam logic [7:0] OCW2_NS_EOI = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P1   = 3'd1,
        ST_G1   = 3'd2,
        ST_P2   = 3'd3,
        ST_VEC  = 3'd4
`ifdef PIC_INTA_EOI_WRITER_EN
        ,
        ST_EW   = 3'd5,
        ST_EG   = 3'd6
`endif
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pic_inta_initiator_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset.
module pic_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Metastability filter chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pic_inta_initiator.sv
// CPU-side INTA initiator: two INTA_n pulses, vector capture, valid/ready handoff.
// Define PIC_INTA_EOI_WRITER_EN to include the non-specific EOI write path.
module pic_inta_initiator
    import pic_inta_initiator_pkg::*;
#(
    parameter int PULSE_CYC = PULSE_CYC_DEF,
    parameter int GAP_CYC   = GAP_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_in,
    input  logic       int_enable,
    input  logic [7:0] data_in,
    output logic       inta_n,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_ready,
    input  logic       eoi_req,
    output logic       eoi_ack,
    output logic       wr_n,
    output logic       a0,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy
);

    localparam int              CW        = $clog2(max2(PULSE_CYC, GAP_CYC) + 1);
    localparam logic [CW-1:0]   PULSE_LD  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0]   GAP_LD    = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0]   CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

    logic          int_s;
    state_e        state_r;
    state_e        state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          cap_s;
    logic          inta_n_r;
    logic [7:0]    vector_r;
    logic          vector_valid_r;
    logic          busy_r;

    pic_sync2 u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (int_in),
        .q     (int_s)
    );

`ifdef PIC_INTA_EOI_WRITER_EN
    logic       ack_s;
    logic       wr_n_r;
    logic       data_oe_r;
    logic [7:0] data_out_r;
    logic       eoi_ack_r;
`endif

    // State and phase counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic; each timed phase loads N-1 on entry and leaves at zero.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        cap_s   = 1'b0;
`ifdef PIC_INTA_EOI_WRITER_EN
        ack_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
`ifdef PIC_INTA_EOI_WRITER_EN
                if (eoi_req) begin
                    state_s = ST_EW;
                    cnt_s   = PULSE_LD;
                end else if (int_s && int_enable) begin
                    state_s = ST_P1;
                    cnt_s   = PULSE_LD;
                end else begin
                    state_s = ST_IDLE;
                end
`else
                if (int_s && int_enable) begin
                    state_s = ST_P1;
                    cnt_s   = PULSE_LD;
                end else begin
                    state_s = ST_IDLE;
                end
`endif
            end
            ST_P1: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_G1;
                    cnt_s   = GAP_LD;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_G1: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_P2;
                    cnt_s   = PULSE_LD;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_P2: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_VEC;
                    cap_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_VEC: begin
                if (vector_valid_r && vector_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_VEC;
                end
            end
`ifdef PIC_INTA_EOI_WRITER_EN
            ST_EW: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_EG;
                    cnt_s   = GAP_LD;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_EG: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_IDLE;
                    ack_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // INTA-side outputs are registered from the next state so strobes align with state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inta_n_r       <= 1'b1;
            vector_r       <= 8'h00;
            vector_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            inta_n_r       <= !((state_s == ST_P1) || (state_s == ST_P2));
            vector_valid_r <= (state_s == ST_VEC);
            busy_r         <= (state_s != ST_IDLE);
            if (cap_s) begin
                vector_r <= data_in;
            end
        end
    end

    assign inta_n       = inta_n_r;
    assign vector       = vector_r;
    assign vector_valid = vector_valid_r;
    assign busy         = busy_r;
    assign a0           = 1'b0;

`ifdef PIC_INTA_EOI_WRITER_EN
    // EOI write strobes; data stays driven through the gap as hold time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_n_r     <= 1'b1;
            data_oe_r  <= 1'b0;
            data_out_r <= 8'h00;
            eoi_ack_r  <= 1'b0;
        end else begin
            wr_n_r     <= (state_s != ST_EW);
            data_oe_r  <= (state_s == ST_EW) || (state_s == ST_EG);
            data_out_r <= ((state_s == ST_EW) || (state_s == ST_EG)) ? OCW2_NS_EOI : 8'h00;
            eoi_ack_r  <= ack_s;
        end
    end

    assign wr_n     = wr_n_r;
    assign data_oe  = data_oe_r;
    assign data_out = data_out_r;
    assign eoi_ack  = eoi_ack_r;
`else
    logic eoi_req_unused_s;
    assign eoi_req_unused_s = eoi_req;
    assign wr_n     = 1'b1;
    assign data_oe  = 1'b0;
    assign data_out = 8'h00;
    assign eoi_ack  = 1'b0;
`endif

endmodule

// File: tb/tb_pic_inta_initiator.sv
// Randomized self-checking bench for pic_inta_initiator against a timing-rule model.
module tb_pic_inta_initiator;

    localparam int P   = 2;
    localparam int G   = 2;
    localparam int WIN = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       int_in;
    logic       int_enable;
    logic [7:0] data_in;
    logic       inta_n;
    logic [7:0] vector;
    logic       vector_valid;
    logic       vector_ready;
    logic       eoi_req;
    logic       eoi_ack;
    logic       wr_n;
    logic       a0;
    logic [7:0] data_out;
    logic       data_oe;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    pic_inta_initiator #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .int_in       (int_in),
        .int_enable   (int_enable),
        .data_in      (data_in),
        .inta_n       (inta_n),
        .vector       (vector),
        .vector_valid (vector_valid),
        .vector_ready (vector_ready),
        .eoi_req      (eoi_req),
        .eoi_ack      (eoi_ack),
        .wr_n         (wr_n),
        .a0           (a0),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bits lo..hi set; cycle k of a transaction maps to bit k.
    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) begin
            if (i >= 0 && i < 64) m[i] = 1'b1;
        end
        return m;
    endfunction

    // One interrupt (optionally preceded by an EOI request), checked as per-cycle activity masks.
    task automatic run_irq(input logic [7:0] vec, input int ready_lat, input int en_delay,
                           input logic eoi);
        int          start, vv, hs;
        logic        eoi_on;
        logic [63:0] o_inta, o_val, o_busy, o_wr, o_oe, o_ack;
        logic [63:0] e_busy;
`ifdef PIC_INTA_EOI_WRITER_EN
        eoi_on = eoi;
`else
        eoi_on = 1'b0;
`endif
        start = eoi_on ? (P + G + 2) : ((en_delay + 1 > 3) ? en_delay + 1 : 3);
        vv    = start + 2 * P + G;
        hs    = vv + ready_lat;
        o_inta = '0; o_val = '0; o_busy = '0; o_wr = '0; o_oe = '0; o_ack = '0;
        int_in       = 1'b1;
        int_enable   = (en_delay == 0);
        eoi_req      = eoi;
        vector_ready = (ready_lat == 0);
        data_in      = ~vec;
        for (int k = 1; k <= WIN; k++) begin
            @(posedge clk); #1;
            o_inta[k] = ~inta_n;
            o_val[k]  = vector_valid && (vector == vec);
            o_busy[k] = busy;
            o_wr[k]   = ~wr_n && data_oe && (data_out == 8'h20) && ~a0;
            o_oe[k]   = data_oe;
            o_ack[k]  = eoi_ack;
            if (!inta_n) int_in = 1'b0;
            if (eoi_ack) eoi_req = 1'b0;
            if (k == en_delay) int_enable = 1'b1;
            vector_ready = (ready_lat == 0) || (k >= hs);
            data_in      = (k == vv - 1) ? vec : ~vec;
        end
        e_busy = span(start, hs) | (eoi_on ? span(1, P + G) : 64'h0);
        check("inta_pulses", o_inta, span(start, start + P - 1) | span(start + P + G, vv - 1));
        check("vector_valid", o_val, span(vv, hs));
        check("busy", o_busy, e_busy);
        check("eoi_write", o_wr, eoi_on ? span(1, P) : 64'h0);
        check("data_oe", o_oe, eoi_on ? span(1, P + G) : 64'h0);
        check("eoi_ack", o_ack, eoi_on ? span(P + G + 1, P + G + 1) : 64'h0);
        check("vector_hold", {56'h0, vector}, {56'h0, vec});
        int_in = 1'b0; eoi_req = 1'b0; vector_ready = 1'b0; int_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Reset hit during the second pulse, then a fresh sequence with INT still high.
    task automatic reset_mid_p2(input logic [7:0] vec);
        int_in = 1'b1; int_enable = 1'b1; data_in = vec; vector_ready = 1'b1;
        for (int k = 1; k <= 3 + P + G; k++) begin
            @(posedge clk); #1;
        end
        check("p2_reached", {63'h0, inta_n}, 64'h0);
        rst_n = 1'b0;
        #1;
        check("rst_inta_n", {63'h0, inta_n}, 64'h1);
        check("rst_valid", {63'h0, vector_valid}, 64'h0);
        check("rst_vector", {56'h0, vector}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        run_irq(vec ^ 8'h3C, 0, 0, 1'b0);
    endtask

    initial begin
        logic [7:0] v;
        int         rl, en;
        logic       eo;
        logic       seen_wr, seen_ack;
        rst_n = 1'b0; int_in = 1'b0; int_enable = 1'b0; data_in = 8'h00;
        vector_ready = 1'b0; eoi_req = 1'b0;
        @(negedge clk); @(negedge clk);
        check("reset_strobes", {60'h0, inta_n, wr_n, a0, data_oe}, 64'hC);
        check("reset_data", {48'h0, vector, data_out}, 64'h0);
        check("reset_flags", {61'h0, vector_valid, eoi_ack, busy}, 64'h0);
        rst_n = 1'b1;

        run_irq(8'h47, 0, 0, 1'b0);
        run_irq(8'h5A, 0, 20, 1'b0);
        run_irq(8'hC3, 5, 0, 1'b0);
        run_irq(8'h91, 0, 0, 1'b1);
        run_irq(8'h47, 0, 0, 1'b0);
        reset_mid_p2(8'hA5);

        for (int t = 0; t < 10; t++) begin
            v  = 8'($urandom_range(1, 255));
            rl = $urandom_range(0, 5);
            en = $urandom_range(0, 6);
            eo = 1'($urandom_range(0, 1));
            if (eo) en = 0;
            run_irq(v, rl, en, eo);
        end

`ifndef PIC_INTA_EOI_WRITER_EN
        seen_wr = 1'b0; seen_ack = 1'b0;
        eoi_req = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            seen_wr  = seen_wr | ~wr_n;
            seen_ack = seen_ack | eoi_ack;
        end
        eoi_req = 1'b0;
        check("no_eoi_wr", {63'h0, seen_wr}, 64'h0);
        check("no_eoi_ack", {63'h0, seen_ack}, 64'h0);
`else
        seen_wr = 1'b0; seen_ack = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
